// File: rtl/seg_scan_driver_if.sv
// Display-side bundle between the countdown core (master) and the scan driver (slave).
// Carries the BCD digits and display controls in, and the active-low pin drives out.
interface seg_scan_driver_if;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        blank_lead;
    logic        blink_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    modport master (
        output digits, dp_mask, blank_lead, blink_en,
        input  an, seg, dp, frame_start
    );

    modport slave (
        input  digits, dp_mask, blank_lead, blink_en,
        output an, seg, dp, frame_start
    );
endinterface

// File: rtl/seg_scan_driver.sv
// 4-digit multiplexed common-anode seven-segment scanner with frame snapshot,
// anti-ghost guard, leading-zero blanking and alarm blink; all pin outputs registered.
module seg_scan_driver #(
    parameter int unsigned SLOT_CYCLES  = 100000,
    parameter int unsigned GUARD_CYCLES = 64,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_driver_if.slave   disp_if
);
    localparam int unsigned SLOT_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [SLOT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic               first_q, first_d;
    logic [15:0]        digits_snap_q, digits_snap_d;
    logic [3:0]         dp_snap_q, dp_snap_d;
    logic               blank_snap_q, blank_snap_d;
    logic               off_snap_q, off_snap_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_off_q, blink_off_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic               frame_start_q, frame_start_d;
    logic               snap_c;
    logic [3:0]         nibble_c;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_q    <= '0;
            idx_q         <= 2'd0;
            first_q       <= 1'b1;
            digits_snap_q <= 16'h0000;
            dp_snap_q     <= 4'h0;
            blank_snap_q  <= 1'b0;
            off_snap_q    <= 1'b0;
            blink_cnt_q   <= '0;
            blink_off_q   <= 1'b0;
            an_q          <= 4'hF;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            idx_q         <= idx_d;
            first_q       <= first_d;
            digits_snap_q <= digits_snap_d;
            dp_snap_q     <= dp_snap_d;
            blank_snap_q  <= blank_snap_d;
            off_snap_q    <= off_snap_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_off_q   <= blink_off_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Scan sequencing, frame snapshot and blink phase
    always_comb begin
        slot_cnt_d    = slot_cnt_q;
        idx_d         = idx_q;
        first_d       = 1'b0;
        snap_c        = 1'b0;
        digits_snap_d = digits_snap_q;
        dp_snap_d     = dp_snap_q;
        blank_snap_d  = blank_snap_q;
        off_snap_d    = off_snap_q;
        blink_cnt_d   = blink_cnt_q;
        blink_off_d   = blink_off_q;

        // The first cycle after reset only takes the snapshot; counters stay at d0/slot 0.
        if (first_q) begin
            snap_c = 1'b1;
        end else if (slot_cnt_q == SLOT_W'(SLOT_CYCLES - 1)) begin
            slot_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
            snap_c     = (idx_q == 2'd3);
        end else begin
            slot_cnt_d = slot_cnt_q + SLOT_W'(1);
        end

        if (snap_c) begin
            digits_snap_d = disp_if.digits;
            dp_snap_d     = disp_if.dp_mask;
            blank_snap_d  = disp_if.blank_lead;
            off_snap_d    = disp_if.blink_en & blink_off_q;
        end

        // The new frame shows the phase held before this frame advances the count.
        if (!disp_if.blink_en) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if (snap_c) begin
            if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    // Pin values for the next cycle, derived from the current slot
    always_comb begin
        an_d          = 4'hF;
        seg_d         = 7'h3F;
        dp_d          = ~dp_snap_q[idx_q];
        frame_start_d = snap_c;
        nibble_c      = digits_snap_q[4*idx_q +: 4];

        case (nibble_c)
            4'd0:    seg_d = 7'h40;
            4'd1:    seg_d = 7'h79;
            4'd2:    seg_d = 7'h24;
            4'd3:    seg_d = 7'h30;
            4'd4:    seg_d = 7'h19;
            4'd5:    seg_d = 7'h12;
            4'd6:    seg_d = 7'h02;
            4'd7:    seg_d = 7'h78;
            4'd8:    seg_d = 7'h00;
            4'd9:    seg_d = 7'h10;
            default: seg_d = 7'h3F;
        endcase

        if ((slot_cnt_q >= SLOT_W'(GUARD_CYCLES)) && !off_snap_q &&
            !((idx_q == 2'd3) && blank_snap_q && (digits_snap_q[15:12] == 4'd0))) begin
            an_d = ~(4'b0001 << idx_q);
        end
    end

    assign disp_if.an          = an_q;
    assign disp_if.seg         = seg_q;
    assign disp_if.dp          = dp_q;
    assign disp_if.frame_start = frame_start_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a frame-level reference model queues the
// expected pin values for every cycle, and a negedge monitor pops and compares them.
module tb_seg_scan_driver;
    localparam int SLOT  = 8;
    localparam int GUARD = 2;
    localparam int BF    = 2;
    localparam int FRAME = 4 * SLOT;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    seg_scan_driver_if dif ();

    seg_scan_driver #(
        .SLOT_CYCLES (SLOT),
        .GUARD_CYCLES(GUARD),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .disp_if(dif)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return (n < 4'd10) ? tbl[n] : 7'h3F;
    endfunction

    task automatic chk(input string name, input logic [12:0] got, input logic [12:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0t: got an=%h seg=%h dp=%b fs=%b, want an=%h seg=%h dp=%b fs=%b",
                     name, $time, got[12:9], got[8:2], got[1], got[0],
                     want[12:9], want[8:2], want[1], want[0]);
        end
    endtask

    // Reference model: frame position m_k (0..FRAME-1) plus the values latched for that frame
    bit          m_first;
    int          m_k;
    logic [15:0] m_dig;
    logic [3:0]  m_dp;
    bit          m_bl;
    bit          m_off;
    int          m_bframe;

    always @(posedge clk) begin
        exp_t e;
        int   di;
        int   sl;
        bit   latch;
        if (rst) begin
            m_first = 1'b1; m_k = 0; m_dig = '0; m_dp = '0;
            m_bl = 1'b0; m_off = 1'b0; m_bframe = 0;
            q.delete();
        end else begin
            di    = m_k / SLOT;
            sl    = m_k % SLOT;
            e.seg = seg_of(m_dig[4*di +: 4]);
            e.dp  = ~m_dp[di];
            e.an  = 4'hF;
            if (sl >= GUARD && !m_off && !(di == 3 && m_bl && m_dig[15:12] == 4'd0))
                e.an[di] = 1'b0;
            latch = m_first || (m_k == FRAME - 1);
            e.fs  = latch;
            q.push_back(e);
            if (!dif.blink_en) m_bframe = 0;
            if (latch) begin
                m_dig = dif.digits;
                m_dp  = dif.dp_mask;
                m_bl  = dif.blank_lead;
                if (dif.blink_en) begin
                    m_off = ((m_bframe / BF) % 2) == 1;
                    m_bframe++;
                end else begin
                    m_off = 1'b0;
                end
                m_k = 0;
                m_first = 1'b0;
            end else begin
                m_k++;
            end
        end
    end

    // Monitor: every cycle out of reset the DUT presents a pin state to compare
    always @(negedge clk) begin
        exp_t e;
        int   lows;
        if (!rst && q.size() > 0) begin
            e = q.pop_front();
            chk("cycle", {dif.an, dif.seg, dif.dp, dif.frame_start}, {e.an, e.seg, e.dp, e.fs});
            lows = 0;
            for (int i = 0; i < 4; i++) if (!dif.an[i]) lows++;
            total++;
            if (lows > 1) begin
                bad++;
                $display("FAIL one_anode at %0t: an=%b has %0d anodes low, want at most 1", $time, dif.an, lows);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic reset_mid();
        tick(1);
        rst = 1'b1;
        #1;
        chk("rst_async", {dif.an, dif.seg, dif.dp, dif.frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
        tick(2);
        chk("rst_hold", {dif.an, dif.seg, dif.dp, dif.frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
        rst = 1'b0;
    endtask

    initial begin
        dif.digits     = 16'h1234;
        dif.dp_mask    = 4'b0100;
        dif.blank_lead = 1'b0;
        dif.blink_en   = 1'b0;
        tick(3);
        chk("rst_init", {dif.an, dif.seg, dif.dp, dif.frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
        rst = 1'b0;

        // Basic scan, then a mid-frame change during the d1 slot
        tick(FRAME + 1 + SLOT + 3);
        dif.digits = 16'h5678;
        tick(2 * FRAME);

        // Reset in the middle of a slot
        tick(13);
        reset_mid();
        tick(FRAME + 5);

        // Leading-zero blanking, unblanked zero, and out-of-range nibble
        dif.digits = 16'h0905; dif.blank_lead = 1'b1;
        tick(2 * FRAME);
        dif.blank_lead = 1'b0;
        tick(2 * FRAME);
        dif.digits = 16'hC9A5;
        tick(2 * FRAME);

        // Blink: several phases, then drop enable during an off phase
        dif.digits = 16'h4321; dif.blink_en = 1'b1;
        tick(6 * FRAME + 10);
        dif.blink_en = 1'b0;
        tick(2 * FRAME);

        // Random inputs, changing at arbitrary cycles, with occasional resets
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 19) == 0) begin
                dif.digits     = 16'($urandom);
                dif.dp_mask    = 4'($urandom);
                dif.blank_lead = 1'($urandom);
                if ($urandom_range(0, 2) == 0) dif.digits[15:12] = 4'd0;
            end
            if ($urandom_range(0, 99) == 0) dif.blink_en = ~dif.blink_en;
            if ($urandom_range(0, 999) == 0) reset_mid();
            tick(1);
        end

        tick(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
